// File: rtl/ultrasonic_ranger_ctrl.sv
// Trigger/echo sequencer for the ultrasonic ranger; feeds echo_width to convert_echo_to_inches.
// Optional feature macro: RANGER_SYNC_EN puts a 2-flop synchroniser in front of the echo pin.
module ultrasonic_ranger_ctrl #(
    parameter int unsigned TRIG_CYCLES    = 120,
    parameter int unsigned PERIOD_CYCLES  = 720000,
    parameter int unsigned TIMEOUT_CYCLES = 360000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic [31:0] echo_width,
    output logic        width_valid,
    output logic        timeout,
    output logic        busy,
    output logic [2:0]  dbg_state_o
);
    // Result handshake: width_valid is a one-cycle strobe with no ready/backpressure;
    // echo_width and timeout are stable from that cycle until the next strobe.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] PERIOD_MAX   = 32'(PERIOD_CYCLES);
    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_VAL  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        trig_q;
    logic        busy_q;
    logic        valid_q;
    logic        timeout_q;
    logic [31:0] width_out_q;
    logic [31:0] trig_cnt_q;
    logic [31:0] wait_cnt_q;
    logic [31:0] width_q;
    logic [31:0] period_q;
    logic        seen_low_q;
    logic        echo_s_q;

`ifdef RANGER_SYNC_EN
    logic echo_meta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_s_q <= 1'b0;
        end else begin
            echo_s_q <= echo;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            width_out_q <= '0;
            trig_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            width_q     <= '0;
            period_q    <= '0;
            seen_low_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (period_q != PERIOD_MAX) begin
                period_q <= period_q + 32'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable || start) begin
                        state_q    <= S_TRIG;
                        trig_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        trig_cnt_q <= '0;
                        period_q   <= '0;
                    end
                end
                S_TRIG: begin
                    if (trig_cnt_q == TRIG_LAST) begin
                        state_q    <= S_WAIT_RISE;
                        trig_q     <= 1'b0;
                        wait_cnt_q <= '0;
                        seen_low_q <= 1'b0;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + 32'd1;
                    end
                end
                S_WAIT_RISE: begin
                    // Only a low seen inside this state arms the rise, so an echo
                    // already high on entry never counts as a rising edge.
                    if (echo_s_q && seen_low_q) begin
                        state_q <= S_MEASURE;
                        width_q <= 32'd1;
                    end else if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_q     <= S_HOLDOFF;
                        width_out_q <= '0;
                        timeout_q   <= 1'b1;
                        valid_q     <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                        if (!echo_s_q) begin
                            seen_low_q <= 1'b1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (!echo_s_q) begin
                        state_q     <= S_HOLDOFF;
                        width_out_q <= width_q;
                        timeout_q   <= 1'b0;
                        valid_q     <= 1'b1;
                    end else if (width_q == TIMEOUT_LAST) begin
                        state_q     <= S_HOLDOFF;
                        width_out_q <= TIMEOUT_VAL;
                        timeout_q   <= 1'b1;
                        valid_q     <= 1'b1;
                    end else begin
                        width_q <= width_q + 32'd1;
                    end
                end
                S_HOLDOFF: begin
                    // Leaving one cycle before saturation makes the next trig edge land
                    // exactly PERIOD_CYCLES after the previous one.
                    if ((period_q >= PERIOD_LAST) && !echo_s_q) begin
                        if (enable) begin
                            state_q    <= S_TRIG;
                            trig_q     <= 1'b1;
                            trig_cnt_q <= '0;
                            period_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig        = trig_q;
    assign busy        = busy_q;
    assign width_valid = valid_q;
    assign timeout     = timeout_q;
    assign echo_width  = width_out_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/ultrasonic_ranger_ctrl.md
# ultrasonic_ranger_ctrl

Sequencer for the ultrasonic range sensor: it generates the trigger pulse, waits for the echo, measures the echo high time in clock cycles, and repeats at a fixed measurement period. It sits between the sensor pins and `convert_echo_to_inches`. It drives that block's `echo_width` input and qualifies each new result with a one-cycle valid strobe. It also handles the no-echo and stuck-echo cases with a timeout so the pipeline never stalls.

## Interface
- `TRIG_CYCLES`, default 120: trigger pulse length in clk cycles (10 us at 12 MHz).
- `PERIOD_CYCLES`, default 720000: minimum spacing between trigger rising edges (60 ms).
- `TIMEOUT_CYCLES`, default 360000: limit for the echo-rise wait, and separately for the echo width (30 ms).
- `clk` in 1: system clock, 12 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: continuous ranging while high.
- `start` in 1: single-shot request, one-cycle pulse; honoured only in IDLE.
- `echo` in 1: sensor echo pin, asynchronous to `clk`.
- `trig` out 1: sensor trigger pin, registered.
- `echo_width` out 32: last measured width in cycles; holds until the next result.
- `width_valid` out 1: one-cycle strobe, asserted when `echo_width` and `timeout` update.
- `timeout` out 1: the last result was a timeout; holds with `echo_width`.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values: `trig`=0, `echo_width`=0, `width_valid`=0, `timeout`=0, `busy`=0, state=IDLE, all counters 0.
- `echo_s` is the internal sampled echo (see Configuration).
- The period counter clears on TRIG entry and saturates at `PERIOD_CYCLES`.
- IDLE:
  - if `enable`=1 or `start`=1, go to TRIG.
- TRIG:
  - `trig`=1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE.
- WAIT_RISE:
  - a wait counter clears on entry.
  - a rising edge on `echo_s` (low, then high) moves to MEASURE with width count = 1.
  - an `echo_s` that is already high on entry is not a rise.
  - if the wait counter reaches `TIMEOUT_CYCLES`, publish `echo_width`=0, `timeout`=1 and go to HOLDOFF.
- MEASURE:
  - the width count increments each cycle `echo_s`=1.
  - on the first cycle `echo_s`=0, publish the count with `timeout`=0 and go to HOLDOFF.
  - if the count reaches `TIMEOUT_CYCLES`, publish `echo_width`=`TIMEOUT_CYCLES`, `timeout`=1 and go to HOLDOFF.
- HOLDOFF:
  - exit when the period counter equals `PERIOD_CYCLES` and `echo_s`=0.
  - if `echo_s` is still high at that point, stay in HOLDOFF until it goes low; this blocks retrigger into a live echo.
  - on exit, go to TRIG if `enable`=1, otherwise to IDLE.
- "Publish" means:
  - `echo_width` and `timeout` are registered in the same cycle;
  - `width_valid`=1 for exactly that one cycle.
- Echo width definition: the number of clk cycles `echo_s` is sampled high, so N high cycles give `echo_width`=N.
- `start` outside IDLE is ignored, not queued.
- `enable` falling mid-cycle: the current measurement completes and publishes, HOLDOFF completes, then the block goes to IDLE.
- `enable` and `start` high together in IDLE give a single TRIG entry.
- Asynchronous reset in any state:
  - `trig` drops immediately and no `width_valid` is emitted;
  - `echo_width` and `timeout` return to 0.
- Counters are 32 bits and never wrap; all compare limits are at most 2^31.

## Timing
- `trig` rises on the first clock edge after the IDLE→TRIG decision. `busy` rises on the same edge.
- Echo pin falling → `width_valid`:
  - 1 cycle after `echo_s` is first seen low;
  - plus 2 cycles of synchroniser delay when `RANGER_SYNC_EN` is defined.
- Back-to-back triggers in continuous mode are `PERIOD_CYCLES` apart, exactly, when the echo ends before the period expires.
- `width_valid` is never asserted in two consecutive cycles.
- `busy` falls on the edge that enters IDLE.

## Configuration
- `RANGER_SYNC_EN`, defined:
  - `echo` passes through a 2-flop synchroniser, so `echo_s` is the second flop;
  - echo latency +2 cycles, width value unchanged.
- `RANGER_SYNC_EN`, undefined:
  - `echo_s` is a single register of `echo` (edge-detect flop only);
  - for benches or for designs where `echo` is already synchronous.

## Test plan
- `start` pulse in IDLE, echo high for 17760 cycles starting 500 cycles after `trig` falls:
  - `trig` is high for 120 cycles;
  - one `width_valid` with `echo_width`=17760 and `timeout`=0;
  - return to IDLE after 720000 cycles; `busy`=0.
- `enable` held high, echo widths 1776 then 3552:
  - trigger rising edges are exactly 720000 cycles apart;
  - two strobes, with values 1776 and 3552.
- No echo after trigger:
  - at 360000 cycles into WAIT_RISE, `width_valid` with `echo_width`=0 and `timeout`=1.
- Echo stuck high after the rise:
  - `width_valid` with `echo_width`=360000 and `timeout`=1;
  - HOLDOFF persists past 720000 cycles until echo falls;
  - the next `trig` follows that fall.
- Echo high before and through the trigger (no low→high edge):
  - treated as no rise;
  - timeout result published with `echo_width`=0.
- `reset` asserted mid-MEASURE:
  - `trig`, `echo_width`, `timeout`, `width_valid` and `busy` are 0 without waiting for a clock edge;
  - after release with `enable`=1, a fresh TRIG of 120 cycles follows.
